decoder_rr_arbiter: RTL and testbench
=====================================

// Module: decoder_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one decoded resource (3-to-8 one-hot select) among 8 requesters.
//  Picks a winner index, drives it as a registered 3-bit select plus its one-hot decode, and holds
//  the grant until release or timeout. Sits between requester logic and the Decoder3to8 select path.
// PARAMETERS
//  MAX_HOLD  16  max consecutive GRANT cycles per winner; 0 = no timeout
//  CNT_W     5   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  req        in   8  request vector, bit i = requester i; level, held until served
//  done       in   1  release pulse from the current owner; ignored unless state==GRANT
//  gnt        out  8  one-hot grant, equals decode of gnt_idx when gnt_valid, else 8'h00
//  gnt_idx    out  3  winning requester index (select for the decoder)
//  gnt_valid  out  1  high while a grant is held (state==GRANT)
//  preempt    out  1  one-cycle pulse: grant ended by MAX_HOLD timeout
// BEHAVIOUR
//  Reset (async assert, sync deassert at input): state=IDLE, ptr=0, gnt=0, gnt_idx=0,
//   gnt_valid=0, preempt=0, hold_cnt=0. Reset mid-grant drops gnt immediately.
//  FSM states: IDLE, GRANT, REL.
//   IDLE:  if |req at edge n -> winner = first set bit searching ptr, ptr+1, ... ptr+7 (mod 8);
//          gnt_idx<=winner, gnt<=1<<winner, gnt_valid<=1, hold_cnt<=1, state<=GRANT.
//          Grant visible in cycle n+1 (1-cycle registered latency). No req -> stay IDLE.
//   GRANT: release when any of: done==1; req[gnt_idx]==0; MAX_HOLD!=0 && hold_cnt==MAX_HOLD.
//          On release: gnt<=0, gnt_valid<=0, ptr<=gnt_idx+1 (3-bit wrap, 7->0), state<=REL.
//          preempt<=1 only when the timeout is the sole cause (done==0 and req still high).
//          Otherwise hold_cnt<=hold_cnt+1 (saturating, never wraps).
//          A grant therefore lasts exactly MAX_HOLD cycles when it times out.
//   REL:   one dead cycle, gnt=0 (break-before-make on the decoder select); preempt<=0;
//          state<=IDLE. Arbitration resumes the next cycle, so minimum gap between grants = 1 cycle.
//  gnt_idx holds its last value outside GRANT; consumers qualify it with gnt_valid.
//  Simultaneous done + req drop + timeout -> a single release, preempt=0.
//  done in IDLE or REL is ignored, with no state change.
//  req changes for non-owners during GRANT do not affect the current grant.
//  Fairness: a requester held continuously is granted within 7 intervening grants.
//  Invariant: $onehot0(gnt) always; gnt!=0 iff gnt_valid.
// TESTING
//  1 Reset: rst_n=0 mid-GRANT with req=8'hFF -> gnt=0, gnt_valid=0 in the same cycle;
//    after release, first grant goes to idx 0.
//  2 Single: req=8'b0000_0100 from IDLE -> next cycle gnt=8'h04, gnt_idx=3'd2;
//    done pulse -> REL (gnt=0), then IDLE.
//  3 Rotation: req=8'hFF held, done pulsed each grant -> grant order 0,1,2,...,7,0,
//    with one REL cycle between grants.
//  4 Wrap: ptr=7 (after serving idx 6), req=8'b1000_0001 -> grants idx 7, then idx 0.
//  5 Timeout: MAX_HOLD=4, req=8'h02 held, no done -> gnt high for exactly 4 cycles,
//    preempt=1 for 1 cycle, then re-grant idx 1 after REL.
//  6 Corner: done and req[gnt_idx] drop on the timeout cycle -> one release, preempt=0;
//    done asserted in IDLE -> no effect.

Source files
------------

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 3-to-8 decoded select among 8 requesters.
// Registered winner index plus one-hot decode, held until release or hold timeout.
module decoder_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic [1:0] {IDLE, GRANT, REL} state_t;

  state_t           state, state_nx;
  logic [2:0]       ptr, ptr_nx, idx_nx;
  logic [2:0]       winner, cand;
  logic             found;
  logic [7:0]       gnt_nx;
  logic             valid_nx, preempt_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic             timeout, owner_rel;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = ptr;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign timeout   = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
  assign owner_rel = done || !req[gnt_idx];

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    idx_nx     = gnt_idx;
    gnt_nx     = gnt;
    valid_nx   = gnt_valid;
    preempt_nx = 1'b0;
    hold_nx    = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          idx_nx   = winner;
          gnt_nx   = 8'b1 << winner;
          valid_nx = 1'b1;
          hold_nx  = CNT_W'(1);
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (owner_rel || timeout) begin
          gnt_nx     = 8'h00;
          valid_nx   = 1'b0;
          ptr_nx     = gnt_idx + 3'd1;
          // preempt flags only a pure timeout; an owner release wins any tie
          preempt_nx = timeout && !owner_rel;
          state_nx   = REL;
        end else if (hold_cnt != '1) begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      REL: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_idx   <= 3'd0;
      gnt       <= 8'h00;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt_idx   <= idx_nx;
      gnt       <= gnt_nx;
      gnt_valid <= valid_nx;
      preempt   <= preempt_nx;
      hold_cnt  <= hold_nx;
    end
  end

  // The decoder select must never see two owners or a grant without valid.
  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt) && ((gnt != 8'h00) == gnt_valid));

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: a cycle table plus hand-written
// reset, rotation, timeout and tie-break sequences (MAX_HOLD=4).
module tb_decoder_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       preempt;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vtab [NVEC];

  decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic applyStimulus(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] ei,
                             input logic ev, input logic ep);
    vec_count++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev || preempt !== ep) begin
      miss_count++;
      $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b preempt=%b, expected gnt=%h idx=%0d valid=%b preempt=%b",
               name, gnt, gnt_idx, gnt_valid, preempt, eg, ei, ev, ep);
    end
  endtask

  initial begin
    // Cycle-by-cycle table starting in IDLE with ptr=0.
    vtab[0]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0}; // single grant idx 2
    vtab[1]  = '{8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0}; // done -> REL, ptr=3
    vtab[2]  = '{8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0}; // IDLE
    vtab[3]  = '{8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0}; // done in IDLE ignored
    vtab[4]  = '{8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vtab[5]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0}; // grant idx 5
    vtab[6]  = '{8'h3F, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0}; // non-owner reqs ignored
    vtab[7]  = '{8'h21, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vtab[8]  = '{8'h01, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0}; // owner req drop -> REL, ptr=6
    vtab[9]  = '{8'h01, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0}; // IDLE
    vtab[10] = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // search 6,7,0 -> idx 0
    vtab[11] = '{8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // REL, ptr=1
    vtab[12] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vtab[13] = '{8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0}; // grant idx 6
    vtab[14] = '{8'h40, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0}; // REL, ptr=7
    vtab[15] = '{8'h81, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0}; // IDLE
    vtab[16] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0}; // wrap: idx 7 first
    vtab[17] = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0}; // REL, ptr 7->0
    vtab[18] = '{8'h81, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0};
    vtab[19] = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0}; // then idx 0
    vtab[20] = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0}; // REL, ptr=1
    vtab[21] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vtab[i].req, vtab[i].done);
      checkOutput($sformatf("table[%0d]", i), vtab[i].gnt, vtab[i].idx, vtab[i].valid, vtab[i].preempt);
    end

    // Async reset in the middle of a grant drops gnt without waiting for an edge.
    applyStimulus(8'hFF, 1'b0);
    checkOutput("pre_reset_grant", 8'h02, 3'd1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_drop", 8'h00, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Rotation with all requesting: 0..7 then 0 again.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("rot_grant[%0d]", k), 8'b1 << (k % 8), 3'(k % 8), 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1);
      checkOutput($sformatf("rot_rel[%0d]", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      checkOutput($sformatf("rot_idle[%0d]", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("rot_done_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Timeout: grant lasts exactly 4 cycles, then one preempt pulse.
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(8'h02, 1'b0);
      checkOutput($sformatf("hold_cycle[%0d]", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    applyStimulus(8'h02, 1'b0);
    checkOutput("timeout_release", 8'h00, 3'd1, 1'b0, 1'b1);
    applyStimulus(8'h02, 1'b0);
    checkOutput("preempt_clears", 8'h00, 3'd1, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0);
    checkOutput("regrant_idx1", 8'h02, 3'd1, 1'b1, 1'b0);

    // done and req drop on the timeout cycle: a single release, no preempt.
    for (int c = 2; c <= 4; c++) begin
      applyStimulus(8'h02, 1'b0);
      checkOutput($sformatf("tie_hold[%0d]", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    applyStimulus(8'h00, 1'b1);
    checkOutput("tie_release", 8'h00, 3'd1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("tie_idle", 8'h00, 3'd1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkOutput("done_in_idle", 8'h00, 3'd1, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0);
    checkOutput("after_idle_done", 8'h08, 3'd3, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
